// File: rtl/mandel_iter.sv
// Mandelbrot/Julia escape-time engine for one pixel, plus the pipelined fixed-point multiplier it drives.
// Optional JULIA_SEED_EN adds z0x/z0y seed ports; without it z0 = 0.
module mul #(
    parameter int WIDTH = 25,
    parameter int FBITS = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic                    done,
    output logic signed [WIDTH-1:0] val,
    output logic                    ovf
);
    localparam int PW = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [3:0]             vld_q, vld_d;
    logic signed [PW-1:0]   prod_q, prod_d;
    logic signed [PW-1:0]   shf_q, shf_d;
    logic signed [WIDTH-1:0] sat_q, sat_d, val_q, val_d;
    logic                   sovf_q, sovf_d, ovf_q, ovf_d;
    logic [PW-WIDTH:0]      top;

    // Four register stages: product, scale, saturate, output.
    always_comb begin
        vld_d  = {vld_q[2:0], start};
        prod_d = PW'(a) * PW'(b);
        shf_d  = prod_q >>> FBITS;
        top    = shf_q[PW-1:WIDTH-1];
        sovf_d = !((&top) || (~|top));
        if (sovf_d) sat_d = shf_q[PW-1] ? S_MIN : S_MAX;
        else        sat_d = shf_q[WIDTH-1:0];
        val_d  = sat_q;
        ovf_d  = sovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            prod_q <= '0;
            shf_q  <= '0;
            sat_q  <= '0;
            sovf_q <= 1'b0;
            val_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            prod_q <= prod_d;
            shf_q  <= shf_d;
            sat_q  <= sat_d;
            sovf_q <= sovf_d;
            val_q  <= val_d;
            ovf_q  <= ovf_d;
        end
    end

    assign done = vld_q[3];
    assign val  = val_q;
    assign ovf  = ovf_q;
endmodule

module mandel_iter #(
    parameter int WIDTH = 25,
    parameter int FBITS = 21,
    parameter int ITERW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] cx,
    input  logic signed [WIDTH-1:0] cy,
`ifdef JULIA_SEED_EN
    input  logic signed [WIDTH-1:0] z0x,
    input  logic signed [WIDTH-1:0] z0y,
`endif
    input  logic [ITERW-1:0]        max_iter,
    output logic                    busy,
    output logic                    done,
    output logic                    escaped,
    output logic [ITERW-1:0]        iter
);
    typedef enum logic [2:0] {S_IDLE, S_MXX, S_MYY, S_MXY, S_CHECK} state_t;

    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0]   FOUR  = (WIDTH+1)'(1) << (FBITS + 2);

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
        if (v > (WIDTH+2)'(S_MAX))      return S_MAX;
        else if (v < (WIDTH+2)'(S_MIN)) return S_MIN;
        else                            return v[WIDTH-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic                    wait_q, wait_d;
    logic signed [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic signed [WIDTH-1:0] xx_q, xx_d, yy_q, yy_d, xy_q, xy_d;
    logic [ITERW-1:0]        max_q, max_d, n_q, n_d, iter_q, iter_d;
    logic                    ovf_any_q, ovf_any_d;
    logic                    busy_q, busy_d, done_q, done_d, esc_q, esc_d;

    logic                    mul_start, mul_done, mul_ovf;
    logic signed [WIDTH-1:0] mul_a, mul_b, mul_val;
    logic signed [WIDTH-1:0] seed_x, seed_y;
    logic signed [WIDTH:0]   mag;
    logic signed [WIDTH+1:0] nx_w, ny_w;

`ifdef JULIA_SEED_EN
    assign seed_x = z0x;
    assign seed_y = z0y;
`else
    assign seed_x = '0;
    assign seed_y = '0;
`endif

    mul #(.WIDTH(WIDTH), .FBITS(FBITS)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .done  (mul_done),
        .val   (mul_val),
        .ovf   (mul_ovf)
    );

    always_comb begin
        mul_a = x_q;
        mul_b = y_q;
        case (state_q)
            S_MXX:   begin mul_a = x_q; mul_b = x_q; end
            S_MYY:   begin mul_a = y_q; mul_b = y_q; end
            default: begin mul_a = x_q; mul_b = y_q; end
        endcase
        // start is a one-cycle pulse in the issue sub-cycle only; holding it would restart mul.
        mul_start = (state_q == S_MXX || state_q == S_MYY || state_q == S_MXY) && !wait_q;

        mag  = (WIDTH+1)'(xx_q) + (WIDTH+1)'(yy_q);
        nx_w = (WIDTH+2)'(xx_q) - (WIDTH+2)'(yy_q) + (WIDTH+2)'(cx_q);
        ny_w = ((WIDTH+2)'(xy_q) <<< 1) + (WIDTH+2)'(cy_q);
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        max_d     = max_q;
        x_d       = x_q;
        y_d       = y_q;
        n_d       = n_q;
        xx_d      = xx_q;
        yy_d      = yy_q;
        xy_d      = xy_q;
        ovf_any_d = ovf_any_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        esc_d     = esc_q;
        iter_d    = iter_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d      = cx;
                    cy_d      = cy;
                    max_d     = max_iter;
                    x_d       = seed_x;
                    y_d       = seed_y;
                    n_d       = '0;
                    ovf_any_d = 1'b0;
                    busy_d    = 1'b1;
                    wait_d    = 1'b0;
                    state_d   = S_MXX;
                end
            end
            S_MXX, S_MYY, S_MXY: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (mul_done) begin
                    wait_d    = 1'b0;
                    ovf_any_d = ovf_any_q | mul_ovf;
                    case (state_q)
                        S_MXX:   begin xx_d = mul_val; state_d = S_MYY;   end
                        S_MYY:   begin yy_d = mul_val; state_d = S_MXY;   end
                        default: begin xy_d = mul_val; state_d = S_CHECK; end
                    endcase
                end
            end
            S_CHECK: begin
                if (ovf_any_q || mag > FOUR) begin
                    esc_d   = 1'b1;
                    iter_d  = n_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (n_q == max_q) begin
                    esc_d   = 1'b0;
                    iter_d  = n_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    x_d       = sat(nx_w);
                    y_d       = sat(ny_w);
                    n_d       = n_q + 1'b1;
                    ovf_any_d = 1'b0;
                    wait_d    = 1'b0;
                    state_d   = S_MXX;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= 1'b0;
            cx_q      <= '0;
            cy_q      <= '0;
            max_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            n_q       <= '0;
            xx_q      <= '0;
            yy_q      <= '0;
            xy_q      <= '0;
            ovf_any_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            esc_q     <= 1'b0;
            iter_q    <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            max_q     <= max_d;
            x_q       <= x_d;
            y_q       <= y_d;
            n_q       <= n_d;
            xx_q      <= xx_d;
            yy_q      <= yy_d;
            xy_q      <= xy_d;
            ovf_any_q <= ovf_any_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            esc_q     <= esc_d;
            iter_q    <= iter_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign escaped = esc_q;
    assign iter    = iter_q;
endmodule
